// File: rtl/pp_ram_pkg.sv
// Shared constants for the ping-pong simple-dual-port RAM: occupancy counter
// sizing and the bit positions of the sticky error flags in a status word.
package pp_ram_pkg;

  localparam int FULL_CNT_W = 2;
  localparam logic [FULL_CNT_W-1:0] FULL_BANKS = 2'd2;

  localparam int ERR_OVF_BIT  = 0;
  localparam int ERR_UDF_BIT  = 1;
  localparam int ERR_ADDR_BIT = 2;
  localparam int ERR_BITS     = 3;

  typedef logic [FULL_CNT_W-1:0] full_cnt_t;
  typedef logic [ERR_BITS-1:0]   err_flags_t;

endpackage

// File: rtl/sdp_ram_core.sv
// Simple-dual-port storage: synchronous write port, registered read port.
// RAM_TYPE selects which ram_style hint the inferred array carries.
module sdp_ram_core #(
  parameter int    DATA_WIDTH = 32,
  parameter int    WORDS      = 128,
  parameter int    AW         = 7,
  parameter string RAM_TYPE   = "block"
) (
  input  logic                  clk,
  input  logic                  i_we,
  input  logic [AW-1:0]         i_waddr,
  input  logic [DATA_WIDTH-1:0] i_wdata,
  input  logic                  i_re,
  input  logic [AW-1:0]         i_raddr,
  output logic [DATA_WIDTH-1:0] o_rdata
);

  // Attributes must be literal on most tools, so each style gets its own array.
  if (RAM_TYPE == "distributed") begin : g_dist
    (* ram_style = "distributed" *) logic [DATA_WIDTH-1:0] r_mem [WORDS];
    always_ff @(posedge clk) begin
      if (i_we) r_mem[i_waddr] <= i_wdata;
      if (i_re) o_rdata <= r_mem[i_raddr];
    end
  end else if (RAM_TYPE == "ultra") begin : g_ultra
    (* ram_style = "ultra" *) logic [DATA_WIDTH-1:0] r_mem [WORDS];
    always_ff @(posedge clk) begin
      if (i_we) r_mem[i_waddr] <= i_wdata;
      if (i_re) o_rdata <= r_mem[i_raddr];
    end
  end else begin : g_block
    (* ram_style = "block" *) logic [DATA_WIDTH-1:0] r_mem [WORDS];
    always_ff @(posedge clk) begin
      if (i_we) r_mem[i_waddr] <= i_wdata;
      if (i_re) o_rdata <= r_mem[i_raddr];
    end
  end

endmodule

// File: rtl/pingpong_sdp_ram.sv
// Double-buffered SDP RAM: the writer fills one bank while the reader drains
// the other; banks swap on last-word markers, with occupancy-based backpressure.
module pingpong_sdp_ram
  import pp_ram_pkg::*;
#(
  parameter int    DATA_WIDTH = 32,
  parameter int    DEPTH      = 64,
  parameter int    ADDRW      = 6,
  parameter string RAM_TYPE   = "block"
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  flush,
  input  logic                  wr_en,
  input  logic [ADDRW-1:0]      wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  wr_last,
  output logic                  wr_ready,
  output logic                  wr_bank,
  input  logic                  rd_en,
  input  logic [ADDRW-1:0]      rd_addr,
  input  logic                  rd_last,
  output logic                  rd_avail,
  output logic                  rd_bank,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  rd_valid,
  output logic                  err_ovf,
  output logic                  err_udf,
  output logic                  err_addr
);

  localparam int PAW = ADDRW + 1;
  localparam logic [PAW-1:0] DEPTH_P = PAW'(DEPTH);

  full_cnt_t  r_fullCnt;
  logic       r_wb;
  logic       r_rb;
  logic       r_rdValid;
  logic       r_rdZero;
  err_flags_t r_err;

  logic                  w_wrReady;
  logic                  w_rdAvail;
  logic                  w_wrAcc;
  logic                  w_rdAcc;
  logic                  w_wrInRange;
  logic                  w_rdInRange;
  logic                  w_wrSwap;
  logic                  w_rdSwap;
  logic                  w_ramWe;
  logic                  w_ramRe;
  logic [PAW-1:0]        w_wrPhys;
  logic [PAW-1:0]        w_rdPhys;
  logic [DATA_WIDTH-1:0] w_ramQ;

  assign w_wrReady   = (r_fullCnt < FULL_BANKS);
  assign w_rdAvail   = (r_fullCnt != '0);
  assign w_wrAcc     = wr_en & w_wrReady & ~flush;
  assign w_rdAcc     = rd_en & w_rdAvail & ~flush;
  assign w_wrInRange = ({1'b0, wr_addr} < DEPTH_P);
  assign w_rdInRange = ({1'b0, rd_addr} < DEPTH_P);
  assign w_wrSwap    = w_wrAcc & wr_last;
  assign w_rdSwap    = w_rdAcc & rd_last;
  assign w_ramWe     = w_wrAcc & w_wrInRange;
  assign w_ramRe     = w_rdAcc & w_rdInRange;

  // Bank 1 starts at DEPTH so a non-power-of-two DEPTH still packs into 2*DEPTH words.
  assign w_wrPhys = r_wb ? (DEPTH_P + {1'b0, wr_addr}) : {1'b0, wr_addr};
  assign w_rdPhys = r_rb ? (DEPTH_P + {1'b0, rd_addr}) : {1'b0, rd_addr};

  sdp_ram_core #(
    .DATA_WIDTH (DATA_WIDTH),
    .WORDS      (2 * DEPTH),
    .AW         (PAW),
    .RAM_TYPE   (RAM_TYPE)
  ) u_core (
    .clk     (clk),
    .i_we    (w_ramWe),
    .i_waddr (w_wrPhys),
    .i_wdata (wr_data),
    .i_re    (w_ramRe),
    .i_raddr (w_rdPhys),
    .o_rdata (w_ramQ)
  );

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_fullCnt <= '0;
      r_wb      <= 1'b0;
      r_rb      <= 1'b0;
    end else if (flush) begin
      r_fullCnt <= '0;
      r_wb      <= 1'b0;
      r_rb      <= 1'b0;
    end else begin
      if (w_wrSwap) r_wb <= ~r_wb;
      if (w_rdSwap) r_rb <= ~r_rb;
      case ({w_wrSwap, w_rdSwap})
        2'b10:   r_fullCnt <= r_fullCnt + full_cnt_t'(1);
        2'b01:   r_fullCnt <= r_fullCnt - full_cnt_t'(1);
        default: r_fullCnt <= r_fullCnt;
      endcase
    end
  end

  // r_rdZero forces rd_data to zero after reset and for out-of-range reads,
  // while the core output register keeps holding its last real word.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_rdValid <= 1'b0;
      r_rdZero  <= 1'b1;
    end else if (flush) begin
      r_rdValid <= 1'b0;
    end else begin
      r_rdValid <= w_rdAcc;
      if (w_rdAcc) r_rdZero <= ~w_rdInRange;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_err <= '0;
    end else if (flush) begin
      r_err <= '0;
    end else begin
      if (wr_en & ~w_wrReady) r_err[ERR_OVF_BIT] <= 1'b1;
      if (rd_en & ~w_rdAvail) r_err[ERR_UDF_BIT] <= 1'b1;
      if ((w_wrAcc & ~w_wrInRange) | (w_rdAcc & ~w_rdInRange))
        r_err[ERR_ADDR_BIT] <= 1'b1;
    end
  end

  assign wr_ready = w_wrReady;
  assign rd_avail = w_rdAvail;
  assign wr_bank  = r_wb;
  assign rd_bank  = r_rb;
  assign rd_valid = r_rdValid;
  assign rd_data  = r_rdZero ? '0 : w_ramQ;
  assign err_ovf  = r_err[ERR_OVF_BIT];
  assign err_udf  = r_err[ERR_UDF_BIT];
  assign err_addr = r_err[ERR_ADDR_BIT];

endmodule

// File: tb/tb_pingpong_sdp_ram.sv
// Self-checking bench for pingpong_sdp_ram (DEPTH=48 so out-of-range addresses
// are reachable): directed scenarios plus randomized traffic against a bank model.
module tb_pingpong_sdp_ram;

  localparam int DW    = 32;
  localparam int DEPTH = 48;
  localparam int ADDRW = 6;

  logic             clk     = 1'b0;
  logic             resetn  = 1'b0;
  logic             flush   = 1'b0;
  logic             wr_en   = 1'b0;
  logic [ADDRW-1:0] wr_addr = '0;
  logic [DW-1:0]    wr_data = '0;
  logic             wr_last = 1'b0;
  logic             rd_en   = 1'b0;
  logic [ADDRW-1:0] rd_addr = '0;
  logic             rd_last = 1'b0;
  logic             wr_ready, wr_bank, rd_avail, rd_bank, rd_valid;
  logic [DW-1:0]    rd_data;
  logic             err_ovf, err_udf, err_addr;

  int checkCount = 0;
  int errorCount = 0;
  bit compareOn  = 1'b0;

  logic [DW-1:0] mMem   [2][64];
  bit            mKnown [2][64];
  int            mCnt;
  bit            mWb, mRb, mValid, mDataKnown, mOvf, mUdf, mAddr;
  logic [DW-1:0] mData;

  pingpong_sdp_ram #(
    .DATA_WIDTH (DW),
    .DEPTH      (DEPTH),
    .ADDRW      (ADDRW),
    .RAM_TYPE   ("block")
  ) dut (
    .clk      (clk),
    .resetn   (resetn),
    .flush    (flush),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .wr_last  (wr_last),
    .wr_ready (wr_ready),
    .wr_bank  (wr_bank),
    .rd_en    (rd_en),
    .rd_addr  (rd_addr),
    .rd_last  (rd_last),
    .rd_avail (rd_avail),
    .rd_bank  (rd_bank),
    .rd_data  (rd_data),
    .rd_valid (rd_valid),
    .err_ovf  (err_ovf),
    .err_udf  (err_udf),
    .err_addr (err_addr)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checkCount++;
    if (actual !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic modelReset();
    mCnt = 0; mWb = 0; mRb = 0; mValid = 0;
    mData = '0; mDataKnown = 1;
    mOvf = 0; mUdf = 0; mAddr = 0;
  endtask

  // Bank-level view: two arrays, an occupancy count and two bank pointers.
  task automatic modelStep();
    bit wrOk, rdOk;
    if (!resetn) begin
      modelReset();
      return;
    end
    if (flush) begin
      mCnt = 0; mWb = 0; mRb = 0; mValid = 0;
      mOvf = 0; mUdf = 0; mAddr = 0;
      return;
    end
    wrOk = wr_en && (mCnt < 2);
    rdOk = rd_en && (mCnt > 0);
    if (wr_en && !wrOk) mOvf = 1;
    if (rd_en && !rdOk) mUdf = 1;
    mValid = rdOk;
    if (rdOk) begin
      if (int'(rd_addr) >= DEPTH) begin
        mData = '0; mDataKnown = 1; mAddr = 1;
      end else begin
        mData = mMem[mRb][rd_addr];
        mDataKnown = mKnown[mRb][rd_addr];
      end
    end
    if (wrOk) begin
      if (int'(wr_addr) >= DEPTH) mAddr = 1;
      else begin
        mMem[mWb][wr_addr] = wr_data;
        mKnown[mWb][wr_addr] = 1;
      end
    end
    if (wrOk && wr_last) begin mCnt++; mWb = !mWb; end
    if (rdOk && rd_last) begin mCnt--; mRb = !mRb; end
  endtask

  task automatic applyStimulus(input bit we, input logic [ADDRW-1:0] wa, input logic [DW-1:0] wd,
                               input bit wl, input bit re, input logic [ADDRW-1:0] ra,
                               input bit rl, input bit fl);
    wr_en = we; wr_addr = wa; wr_data = wd; wr_last = wl;
    rd_en = re; rd_addr = ra; rd_last = rl; flush = fl;
    @(posedge clk);
    modelStep();
    #1;
  endtask

  task automatic idle();
    applyStimulus(0, '0, '0, 0, 0, '0, 0, 0);
  endtask

  task automatic fillBank(input int base);
    for (int i = 0; i < DEPTH; i++)
      applyStimulus(1, ADDRW'(i), DW'(base + i), (i == DEPTH - 1), 0, '0, 0, 0);
  endtask

  task automatic drainBank(input int base);
    for (int i = 0; i < DEPTH; i++) begin
      applyStimulus(0, '0, '0, 0, 1, ADDRW'(i), (i == DEPTH - 1), 0);
      checkOutput("drain rd_data", rd_data, DW'(base + i));
      checkOutput("drain rd_valid", 32'(rd_valid), 32'd1);
    end
  endtask

  always @(negedge clk) begin
    if (compareOn) begin
      checkOutput("cmp wr_ready", 32'(wr_ready), 32'(mCnt < 2));
      checkOutput("cmp rd_avail", 32'(rd_avail), 32'(mCnt > 0));
      checkOutput("cmp wr_bank", 32'(wr_bank), 32'(mWb));
      checkOutput("cmp rd_bank", 32'(rd_bank), 32'(mRb));
      checkOutput("cmp rd_valid", 32'(rd_valid), 32'(mValid));
      checkOutput("cmp err_ovf", 32'(err_ovf), 32'(mOvf));
      checkOutput("cmp err_udf", 32'(err_udf), 32'(mUdf));
      checkOutput("cmp err_addr", 32'(err_addr), 32'(mAddr));
      if (mDataKnown) checkOutput("cmp rd_data", rd_data, mData);
    end
  end

  initial begin
    modelReset();
    repeat (3) idle();
    resetn = 1'b1;
    compareOn = 1'b1;
    $display("[TB] reset released");
    checkOutput("reset wr_ready", 32'(wr_ready), 32'd1);
    checkOutput("reset rd_avail", 32'(rd_avail), 32'd0);
    checkOutput("reset rd_valid", 32'(rd_valid), 32'd0);
    checkOutput("reset rd_data", rd_data, 32'd0);
    checkOutput("reset errs", {29'd0, err_ovf, err_udf, err_addr}, 32'd0);

    fillBank('h100);
    checkOutput("fill wr_bank", 32'(wr_bank), 32'd1);
    checkOutput("fill rd_avail", 32'(rd_avail), 32'd1);
    checkOutput("fill wr_ready", 32'(wr_ready), 32'd1);
    checkOutput("fill model cnt", 32'(mCnt), 32'd1);

    drainBank('h100);
    checkOutput("drain rd_bank", 32'(rd_bank), 32'd1);
    checkOutput("drain rd_avail", 32'(rd_avail), 32'd0);

    $display("[TB] backpressure");
    fillBank('h200);
    fillBank('h300);
    checkOutput("bp wr_ready", 32'(wr_ready), 32'd0);
    applyStimulus(1, ADDRW'(5), 32'hDEAD, 0, 0, '0, 0, 0);
    checkOutput("bp err_ovf", 32'(err_ovf), 32'd1);
    drainBank('h200);

    $display("[TB] concurrent swap");
    for (int i = 0; i < DEPTH; i++) begin
      applyStimulus(1, ADDRW'(i), DW'('h400 + i), (i == DEPTH - 1),
                    1, ADDRW'(i), (i == DEPTH - 1), 0);
      checkOutput("swap rd_data", rd_data, DW'('h300 + i));
    end
    checkOutput("swap wr_bank", 32'(wr_bank), 32'd0);
    checkOutput("swap rd_bank", 32'(rd_bank), 32'd1);
    checkOutput("swap rd_avail", 32'(rd_avail), 32'd1);
    checkOutput("swap model cnt", 32'(mCnt), 32'd1);
    drainBank('h400);

    $display("[TB] boundaries");
    applyStimulus(1, ADDRW'(50), 32'hBEEF, 0, 0, '0, 0, 0);
    checkOutput("oor err_addr", 32'(err_addr), 32'd1);
    applyStimulus(1, ADDRW'(3), 32'h503, 1, 0, '0, 0, 0);
    applyStimulus(0, '0, '0, 0, 1, ADDRW'(50), 0, 0);
    checkOutput("oor rd_data", rd_data, 32'd0);
    checkOutput("oor rd_valid", 32'(rd_valid), 32'd1);
    applyStimulus(0, '0, '0, 0, 1, ADDRW'(3), 1, 0);
    checkOutput("oor neighbour", rd_data, 32'h503);
    idle();
    applyStimulus(0, '0, '0, 0, 1, ADDRW'(0), 0, 0);
    checkOutput("udf err_udf", 32'(err_udf), 32'd1);
    checkOutput("udf rd_valid", 32'(rd_valid), 32'd0);

    $display("[TB] flush");
    fillBank('h600);
    for (int i = 0; i <= 5; i++)
      applyStimulus(1, ADDRW'(i), DW'('h700 + i), 0, 0, '0, 0, (i == 5));
    checkOutput("flush wr_ready", 32'(wr_ready), 32'd1);
    checkOutput("flush rd_avail", 32'(rd_avail), 32'd0);
    checkOutput("flush wr_bank", 32'(wr_bank), 32'd0);
    checkOutput("flush errs", {29'd0, err_ovf, err_udf, err_addr}, 32'd0);
    idle();

    $display("[TB] random traffic");
    for (int n = 0; n < 3000; n++) begin
      applyStimulus($urandom_range(0, 3) != 0, ADDRW'($urandom_range(0, 63)), $urandom,
                    $urandom_range(0, 15) == 0,
                    $urandom_range(0, 2) != 0, ADDRW'($urandom_range(0, 63)),
                    $urandom_range(0, 15) == 0,
                    $urandom_range(0, 299) == 0);
    end

    $display("[TB] async reset");
    applyStimulus(0, '0, '0, 0, 0, '0, 0, 1);
    fillBank('h800);
    applyStimulus(0, '0, '0, 0, 1, ADDRW'(2), 0, 0);
    checkOutput("pre-reset rd_valid", 32'(rd_valid), 32'd1);
    checkOutput("pre-reset rd_data", rd_data, 32'h802);
    #2;
    resetn = 1'b0;
    modelReset();
    #1;
    checkOutput("async rd_valid", 32'(rd_valid), 32'd0);
    checkOutput("async rd_data", rd_data, 32'd0);
    checkOutput("async rd_avail", 32'(rd_avail), 32'd0);
    idle();
    idle();
    resetn = 1'b1;
    repeat (3) idle();

    compareOn = 1'b0;
    $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
    $finish;
  end

endmodule
